// File: rtl/irq_ctrl.sv
// irq_ctrl: two-source interrupt request controller.
//
// Synchronises two asynchronous interrupt lines, latches their rising edges as
// pending requests and issues one request at a time to the interrupt
// coprocessor as a REQ_CYCLES-long ireq pulse with a one-hot ivec. Further
// requests are held off until a rising edge on irep. Source 0 wins ties.
//
// Optional feature: define IRQ_MASK_EN to add a writable enable mask.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth per input line (2..4)
//   REQ_CYCLES   cycles ireq stays high per request (1..3)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   irq_in[1:0]  asynchronous interrupt lines, bit 0 = highest priority
//   irep         return-from-interrupt strobe, rising edge used
//   mask_we      mask write enable            (IRQ_MASK_EN only)
//   mask_wdata   new mask value               (IRQ_MASK_EN only)
//   mask         current mask, 1 = enabled    (IRQ_MASK_EN only)
//   ireq         request to the coprocessor
//   ivec         one-hot source of the current request
//   pending      latched, not-yet-issued requests
//   in_service   one-hot source being serviced, 00 when idle
module irq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REQ_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] irq_in,
    input  logic       irep,
`ifdef IRQ_MASK_EN
    input  logic       mask_we,
    input  logic [1:0] mask_wdata,
    output logic [1:0] mask,
`endif
    output logic       ireq,
    output logic [1:0] ivec,
    output logic [1:0] pending,
    output logic [1:0] in_service
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    localparam logic [1:0] LAST_CNT = 2'(REQ_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] sync_q [SYNC_STAGES];
    logic [1:0] dly_q;
    logic       irep_q, irep_qq;

    logic [1:0] irq_edge;
    logic [1:0] mask_w;
    logic [1:0] eligible;
    logic [1:0] winner;
    logic [1:0] clr;
    logic       irep_rise;
    logic       ireq_d;
    logic [1:0] ivec_d, pending_d, in_service_d;

    // Input synchronisers and edge-detect delay registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            dly_q   <= '0;
            irep_q  <= 1'b0;
            irep_qq <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            dly_q   <= sync_q[SYNC_STAGES-1];
            irep_q  <= irep;
            irep_qq <= irep_q;
        end
    end

    assign irq_edge  = sync_q[SYNC_STAGES-1] & ~dly_q;
    // irep is registered first so its edge is seen one cycle after sampling.
    assign irep_rise = irep_q & ~irep_qq;

`ifdef IRQ_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= 2'b11;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end
    assign mask_w = mask;
`else
    assign mask_w = 2'b11;
`endif

    assign eligible = pending & mask_w;
    assign winner   = eligible[0] ? 2'b01 : (eligible[1] ? 2'b10 : 2'b00);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ireq       <= 1'b0;
            ivec       <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ireq       <= ireq_d;
            ivec       <= ivec_d;
            pending    <= pending_d;
            in_service <= in_service_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (|eligible) state_d = StReq;
            StReq:     if (cnt_q == LAST_CNT) state_d = StService;
            StService: if (irep_rise) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and hold counter.
    always_comb begin
        ireq_d       = ireq;
        ivec_d       = ivec;
        in_service_d = in_service;
        cnt_d        = cnt_q;
        clr          = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    ireq_d       = 1'b1;
                    ivec_d       = winner;
                    in_service_d = winner;
                    cnt_d        = '0;
                    clr          = winner;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) ireq_d = 1'b0;
            end
            StService: begin
                if (irep_rise) in_service_d = 2'b00;
            end
            default: begin
                ireq_d = 1'b0;
            end
        endcase
        // A new edge in the same cycle as the issue clear keeps the bit set.
        pending_d = (pending & ~clr) | irq_edge;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl with default
// parameters (SYNC_STAGES=2, REQ_CYCLES=3). Inputs change 1 time unit after a
// rising edge and outputs are checked at that same point.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] irq_in;
    logic       irep;
    logic       ireq;
    logic [1:0] ivec, pending, in_service;
`ifdef IRQ_MASK_EN
    logic       mask_we;
    logic [1:0] mask_wdata;
    logic [1:0] mask;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .SYNC_STAGES(2),
        .REQ_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .irep      (irep),
`ifdef IRQ_MASK_EN
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .mask      (mask),
`endif
        .ireq      (ireq),
        .ivec      (ivec),
        .pending   (pending),
        .in_service(in_service)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic [1:0] v,
                           input logic [1:0] p, input logic [1:0] s);
        check({tag, ".ireq"}, 32'(ireq), 32'(r));
        check({tag, ".ivec"}, 32'(ivec), 32'(v));
        check({tag, ".pending"}, 32'(pending), 32'(p));
        check({tag, ".in_service"}, 32'(in_service), 32'(s));
    endtask

    // Pulse irep for one cycle from an idle-waiting SERVICE; returns after the
    // edge where the FSM is back in IDLE.
    task automatic ack();
        irep = 1'b1;
        tick(1);
        irep = 1'b0;
        tick(1);
    endtask

    initial begin
        rst    = 1'b1;
        irq_in = 2'b00;
        irep   = 1'b0;
`ifdef IRQ_MASK_EN
        mask_we    = 1'b0;
        mask_wdata = 2'b00;
`endif
        tick(3);
        chk_all("reset", 1'b0, 2'b00, 2'b00, 2'b00);
`ifdef IRQ_MASK_EN
        check("reset.mask", 32'(mask), 32'h3);
`endif
        rst = 1'b0;
        tick(3);

        // Single source: rise sampled at edge k.
        irq_in = 2'b01;
        tick(1);                                   // k
        tick(2);                                   // k+2
        chk_all("single.k2", 1'b0, 2'b00, 2'b01, 2'b00);
        tick(1);                                   // k+3
        chk_all("single.k3", 1'b1, 2'b01, 2'b00, 2'b01);
        tick(1);
        chk_all("single.k4", 1'b1, 2'b01, 2'b00, 2'b01);
        tick(1);
        chk_all("single.k5", 1'b1, 2'b01, 2'b00, 2'b01);
        tick(1);
        chk_all("single.k6", 1'b0, 2'b01, 2'b00, 2'b01);
        tick(3);
        chk_all("single.wait", 1'b0, 2'b01, 2'b00, 2'b01);
        irep = 1'b1;
        tick(1);                                   // irep registered
        check("single.irep0.in_service", 32'(in_service), 32'h1);
        irep = 1'b0;
        tick(1);
        chk_all("single.irep1", 1'b0, 2'b01, 2'b00, 2'b00);
        tick(2);
        check("single.idle.ireq", 32'(ireq), 32'h0);

        // Simultaneous sources.
        irq_in = 2'b00;
        tick(3);
        irq_in = 2'b11;
        tick(3);                                   // k+2
        check("simul.k2.pending", 32'(pending), 32'h3);
        tick(1);
        chk_all("simul.k3", 1'b1, 2'b01, 2'b10, 2'b01);
        tick(3);
        chk_all("simul.k6", 1'b0, 2'b01, 2'b10, 2'b01);
        irep = 1'b1;
        tick(1);                                   // e
        check("simul.e.ireq", 32'(ireq), 32'h0);
        irep = 1'b0;
        tick(1);                                   // e+1
        chk_all("simul.e1", 1'b0, 2'b01, 2'b10, 2'b00);
        tick(1);                                   // e+2
        chk_all("simul.e2", 1'b1, 2'b10, 2'b00, 2'b10);
        tick(3);
        chk_all("simul.svc", 1'b0, 2'b10, 2'b00, 2'b10);

        // Merge: three rising edges on irq_in[1] while in SERVICE.
        for (int i = 0; i < 3; i++) begin
            irq_in = 2'b01;
            tick(1);
            irq_in = 2'b11;
            tick(1);
        end
        irq_in = 2'b01;
        tick(4);
        chk_all("merge.svc", 1'b0, 2'b10, 2'b10, 2'b10);
        ack();
        check("merge.idle.in_service", 32'(in_service), 32'h0);
        tick(1);                                   // REQ cycle 1
        chk_all("merge.req", 1'b1, 2'b10, 2'b00, 2'b10);
        // irep pulse during REQ must be ignored.
        irep = 1'b1;
        tick(1);
        irep = 1'b0;
        tick(1);
        check("ignore.req3.ireq", 32'(ireq), 32'h1);
        tick(1);
        chk_all("ignore.svc", 1'b0, 2'b10, 2'b00, 2'b10);
        tick(4);
        chk_all("ignore.wait", 1'b0, 2'b10, 2'b00, 2'b10);
        ack();
        tick(4);
        chk_all("merge.once", 1'b0, 2'b10, 2'b00, 2'b00);

        // Reset during the second REQ cycle.
        irq_in = 2'b00;
        tick(3);
        irq_in = 2'b11;
        tick(4);
        chk_all("rstmid.req1", 1'b1, 2'b01, 2'b10, 2'b01);
        tick(1);
        rst    = 1'b1;
        irq_in = 2'b00;
        tick(1);
        chk_all("rstmid.after", 1'b0, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick(5);
        chk_all("rstmid.quiet", 1'b0, 2'b00, 2'b00, 2'b00);
        irq_in = 2'b01;
        tick(4);
        chk_all("rstmid.new", 1'b1, 2'b01, 2'b00, 2'b01);
        tick(3);
        ack();
        irq_in = 2'b00;
        tick(3);
        check("rstmid.idle.in_service", 32'(in_service), 32'h0);

        // Same-cycle set and clear of pending[0].
        irq_in = 2'b10;
        tick(4);                                   // k+3
        chk_all("setclr.req1", 1'b1, 2'b10, 2'b00, 2'b10);
        irq_in = 2'b11;
        tick(1);
        irq_in = 2'b10;
        tick(2);                                   // SERVICE
        chk_all("setclr.svc", 1'b0, 2'b10, 2'b01, 2'b10);
        irq_in = 2'b11;                            // new edge lands at issue edge
        irep   = 1'b1;
        tick(1);
        irep = 1'b0;
        tick(2);
        chk_all("setclr.issue", 1'b1, 2'b01, 2'b01, 2'b01);
        tick(3);
        ack();
        tick(1);
        chk_all("setclr.reissue", 1'b1, 2'b01, 2'b00, 2'b01);
        tick(3);
        ack();
        irq_in = 2'b00;
        tick(3);

`ifdef IRQ_MASK_EN
        mask_we    = 1'b1;
        mask_wdata = 2'b10;
        tick(1);
        mask_we = 1'b0;
        check("mask.write", 32'(mask), 32'h2);
        irq_in = 2'b01;
        tick(1);
        irq_in = 2'b00;
        tick(6);
        chk_all("mask.blocked", 1'b0, 2'b01, 2'b01, 2'b00);
        mask_we    = 1'b1;
        mask_wdata = 2'b11;
        tick(1);
        mask_we = 1'b0;
        tick(1);
        chk_all("mask.unmask", 1'b1, 2'b01, 2'b00, 2'b01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
